// File: rtl/mtl_disp_pkg.sv
// Shared constants, types and helpers for the banded MTL frame-source controller.
// Imported by the MMU-side interface and the controller top.
package mtl_disp_pkg;

    localparam int DEF_ADDR_W = 24;

    typedef logic [DEF_ADDR_W-1:0] band_addr_t;

    localparam band_addr_t  IMG_SIZE_WORDS = 24'd768000;
    localparam logic [31:0] BG_YCBCR       = 32'h001080D0;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Width of a band index; a single band still needs one bit.
    function automatic int band_count_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mtl_band_display_controller_if.sv
// MMU-facing bundle: one read port per band (reload pulse, read strobe, address window, data).
// The controller drives the master side; the MMU (or a bench) drives the slave side.
interface mtl_band_display_controller_if
    import mtl_disp_pkg::*;
#(
    parameter int N_BANDS = 2,
    parameter int ADDR_W  = DEF_ADDR_W
);

    logic [N_BANDS-1:0]        o_load_new;
    logic [N_BANDS-1:0]        o_read_enable;
    logic [N_BANDS*ADDR_W-1:0] o_base_address;
    logic [N_BANDS*ADDR_W-1:0] o_max_address;
    logic [N_BANDS*32-1:0]     i_readdata;

    modport master (
        output o_load_new,
        output o_read_enable,
        output o_base_address,
        output o_max_address,
        input  i_readdata
    );

    modport slave (
        input  o_load_new,
        input  o_read_enable,
        input  o_base_address,
        input  o_max_address,
        output i_readdata
    );

endinterface

// File: rtl/mtl_band_select.sv
// Maps the current LCD row to a band index and its one-hot form using a comparator chain
// (no divider). Rows past the last band boundary fall into the last band.
module mtl_band_select #(
    parameter int N_BANDS = 2,
    parameter int BAND_H  = 240,
    parameter int BAND_W  = 1
) (
    input  logic [9:0]         i_current_y,
    output logic [BAND_W-1:0]  band,
    output logic [N_BANDS-1:0] band_onehot
);

    // Thresholds rise monotonically, so the last boundary passed wins.
    always_comb begin
        band = '0;
        for (int k = 1; k < N_BANDS; k++) begin
            if (i_current_y >= 10'(k * BAND_H)) begin
                band = BAND_W'(k);
            end
        end
    end

    always_comb begin
        band_onehot = '0;
        for (int k = 0; k < N_BANDS; k++) begin
            band_onehot[k] = (band == BAND_W'(k));
        end
    end

endmodule

// File: rtl/mtl_band_display_controller.sv
// Banded MTL frame source: tracks the requested slide, recomputes per-band MMU address windows
// one band per cycle after each frame end (tear-free), and muxes pixel data by the current row.
module mtl_band_display_controller
    import mtl_disp_pkg::*;
#(
    parameter int          N_BANDS  = 2,
    parameter int          V_RES    = 480,
    parameter band_addr_t  IMG_SIZE = IMG_SIZE_WORDS,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          IMG_W    = 5,
    parameter logic [31:0] BG_COLOR = BG_YCBCR
) (
    input  logic        iCLK_33,
    input  logic        iRST_n,
    input  logic [7:0]  iImg_Tot,
    input  logic        image_loaded,
    input  logic        iGest_E,
    input  logic        iGest_W,
    input  logic        iMode_Split,
    input  logic        iNew_Frame,
    input  logic        iEnd_Frame,
    input  logic        i_next_active,
    input  logic [9:0]  i_current_y,
    output logic [31:0] o_pixel_data,
    output logic        o_busy,
    mtl_band_display_controller_if.master mmu
);

    localparam int                BAND_H  = V_RES / N_BANDS;
    localparam int                BAND_W  = band_count_bits(N_BANDS);
    localparam logic [ADDR_W-1:0] IMG_A   = ADDR_W'(IMG_SIZE);
    localparam logic [ADDR_W-1:0] SLICE_A = ADDR_W'(IMG_SIZE / N_BANDS);
    localparam logic [BAND_W-1:0] K_LAST  = BAND_W'(N_BANDS - 1);

    // Forward/backward step through slides 0..last with wrap-around.
    function automatic logic [IMG_W-1:0] step_slide(
        input logic [IMG_W-1:0] idx,
        input logic [IMG_W-1:0] last,
        input logic             fwd
    );
        if (fwd) return (idx == last) ? '0 : idx + 1'b1;
        else     return (idx == '0) ? last : idx - 1'b1;
    endfunction

    logic [IMG_W-1:0] tot_w;
    logic [IMG_W-1:0] t_last;
    logic             unused_tot_hi;

    // A slide count of zero behaves as one slide.
    assign tot_w         = iImg_Tot[IMG_W-1:0];
    assign t_last        = (tot_w == '0) ? '0 : tot_w - 1'b1;
    assign unused_tot_hi = ^iImg_Tot;

    logic [IMG_W-1:0] pend_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK_33 or negedge iRST_n) begin
        if (!iRST_n) begin
            pend_q <= '0;
        end else if (pend_q > t_last) begin
            pend_q <= '0;
        end else if (iGest_E ^ iGest_W) begin
            pend_q <= step_slide(pend_q, t_last, iGest_W);
        end
    end

    state_t            state_q, state_d;
    logic [BAND_W-1:0] k_q, k_d;
    logic [IMG_W-1:0]  idx_q, idx_d;
    logic [IMG_W-1:0]  cur_q, cur_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] base_q [N_BANDS];
    logic [ADDR_W-1:0] base_d [N_BANDS];
    logic [ADDR_W-1:0] max_q  [N_BANDS];
    logic [ADDR_W-1:0] max_d  [N_BANDS];
    logic [ADDR_W-1:0] slot_base, slot_span;

    // Window for the band being computed this cycle.
    always_comb begin
        if (mode_q) begin
            slot_base = ADDR_W'(idx_q) * IMG_A;
            slot_span = IMG_A;
        end else begin
            slot_base = ADDR_W'(cur_q) * IMG_A + ADDR_W'(k_q) * SLICE_A;
            slot_span = SLICE_A;
        end
    end

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        mode_d  = mode_q;
        base_d  = base_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (iEnd_Frame) begin
                    state_d = CALC;
                    cur_d   = pend_q;
                    idx_d   = pend_q;
                    mode_d  = iMode_Split;
                    k_d     = '0;
                end
            end
            CALC: begin
                base_d[k_q] = slot_base;
                max_d[k_q]  = slot_base + slot_span;
                if (mode_q) begin
                    idx_d = step_slide(idx_q, t_last, 1'b1);
                end
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the address windows are reset because they have a defined power-on layout (slide 0,
    // sliced); an asynchronous reset mid-calculation restores that layout in full.
    always_ff @(posedge iCLK_33 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            cur_q   <= '0;
            mode_q  <= 1'b0;
            for (int k = 0; k < N_BANDS; k++) begin
                base_q[k] <= ADDR_W'(k) * SLICE_A;
                max_q[k]  <= ADDR_W'(k) * SLICE_A + SLICE_A;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            max_q   <= max_d;
        end
    end

    logic [N_BANDS-1:0] load_new_q;

    always_ff @(posedge iCLK_33 or negedge iRST_n) begin
        if (!iRST_n) begin
            load_new_q <= '0;
        end else begin
            load_new_q <= {N_BANDS{iNew_Frame}};
        end
    end

    logic [BAND_W-1:0]  band_idx;
    logic [N_BANDS-1:0] band_onehot;
    logic [31:0]        readdata_arr [N_BANDS];

    mtl_band_select #(
        .N_BANDS (N_BANDS),
        .BAND_H  (BAND_H),
        .BAND_W  (BAND_W)
    ) u_band_select (
        .i_current_y (i_current_y),
        .band        (band_idx),
        .band_onehot (band_onehot)
    );

    for (genvar gk = 0; gk < N_BANDS; gk++) begin : g_port
        assign mmu.o_base_address[gk*ADDR_W +: ADDR_W] = base_q[gk];
        assign mmu.o_max_address[gk*ADDR_W +: ADDR_W]  = max_q[gk];
        assign readdata_arr[gk]                        = mmu.i_readdata[gk*32 +: 32];
    end

    assign mmu.o_load_new    = load_new_q;
    assign mmu.o_read_enable = i_next_active ? band_onehot : '0;
    assign o_pixel_data      = image_loaded ? readdata_arr[band_idx] : BG_COLOR;
    assign o_busy            = (state_q == CALC);

    // Blanking must cover the N_BANDS-cycle recalculation; a new frame starting mid-CALC is an upstream fault.
    a_no_frame_start_in_calc: assert property (
        @(posedge iCLK_33) disable iff (!iRST_n) !(iNew_Frame && state_q == CALC)
    );

endmodule

// File: tb/tb_mtl_band_display_controller.sv
// Directed bench for the banded display controller: a 2-band and a 4-band instance share
// the control inputs; each task drives one scenario and checks hand-computed values.
module tb_mtl_band_display_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tot;
    logic       image_loaded, gest_e, gest_w, mode_split, new_frame, end_frame, next_active;
    logic [9:0] cur_y;
    logic [31:0] pix2, pix4;
    logic        busy2, busy4;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    mtl_band_display_controller_if #(.N_BANDS(2), .ADDR_W(24)) mmu2 ();
    mtl_band_display_controller_if #(.N_BANDS(4), .ADDR_W(24)) mmu4 ();

    mtl_band_display_controller #(.N_BANDS(2), .V_RES(480)) dut2 (
        .iCLK_33(clk), .iRST_n(rst_n), .iImg_Tot(tot), .image_loaded(image_loaded),
        .iGest_E(gest_e), .iGest_W(gest_w), .iMode_Split(mode_split),
        .iNew_Frame(new_frame), .iEnd_Frame(end_frame), .i_next_active(next_active),
        .i_current_y(cur_y), .o_pixel_data(pix2), .o_busy(busy2), .mmu(mmu2)
    );

    mtl_band_display_controller #(.N_BANDS(4), .V_RES(480)) dut4 (
        .iCLK_33(clk), .iRST_n(rst_n), .iImg_Tot(tot), .image_loaded(image_loaded),
        .iGest_E(gest_e), .iGest_W(gest_w), .iMode_Split(mode_split),
        .iNew_Frame(new_frame), .iEnd_Frame(end_frame), .i_next_active(next_active),
        .i_current_y(cur_y), .o_pixel_data(pix4), .o_busy(busy4), .mmu(mmu4)
    );

    logic [23:0] base2 [2];
    logic [23:0] max2  [2];
    logic [23:0] base4 [4];
    logic [23:0] max4  [4];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            base2[k] = mmu2.o_base_address[k*24 +: 24];
            max2[k]  = mmu2.o_max_address[k*24 +: 24];
        end
        for (int k = 0; k < 4; k++) begin
            base4[k] = mmu4.o_base_address[k*24 +: 24];
            max4[k]  = mmu4.o_max_address[k*24 +: 24];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_w();
        gest_w = 1'b1; tick(); gest_w = 1'b0;
    endtask

    task automatic pulse_e();
        gest_e = 1'b1; tick(); gest_e = 1'b0;
    endtask

    // Frame end, then wait (bounded) for both instances to finish; returns busy cycle counts.
    task automatic run_frame(input logic mode, output int c2, output int c4);
        int guard;
        mode_split = mode;
        end_frame  = 1'b1; tick(); end_frame = 1'b0;
        c2 = 0; c4 = 0; guard = 0;
        while ((busy2 || busy4) && guard < 20) begin
            if (busy2) c2++;
            if (busy4) c4++;
            guard++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (base2[0] !== 24'd0) begin n_failed++; $display("FAIL reset_base2_0: got %0d expected 0", base2[0]); end
        n_tests++; if (base2[1] !== 24'd384000) begin n_failed++; $display("FAIL reset_base2_1: got %0d expected 384000", base2[1]); end
        n_tests++; if (max2[0] !== 24'd384000) begin n_failed++; $display("FAIL reset_max2_0: got %0d expected 384000", max2[0]); end
        n_tests++; if (max2[1] !== 24'd768000) begin n_failed++; $display("FAIL reset_max2_1: got %0d expected 768000", max2[1]); end
        n_tests++; if (mmu2.o_load_new !== 2'b00) begin n_failed++; $display("FAIL reset_load_new: got %b expected 00", mmu2.o_load_new); end
        n_tests++; if (busy2 !== 1'b0) begin n_failed++; $display("FAIL reset_busy: got %b expected 0", busy2); end
        n_tests++; if (base4[3] !== 24'd576000) begin n_failed++; $display("FAIL reset_base4_3: got %0d expected 576000", base4[3]); end
        n_tests++; if (max4[3] !== 24'd768000) begin n_failed++; $display("FAIL reset_max4_3: got %0d expected 768000", max4[3]); end
    endtask

    task automatic test_slide_split();
        int c2, c4;
        tot = 8'd4;
        repeat (3) pulse_w();
        run_frame(1'b1, c2, c4);
        n_tests++; if (c2 != 2) begin n_failed++; $display("FAIL split_busy2_cycles: got %0d expected 2", c2); end
        n_tests++; if (c4 != 4) begin n_failed++; $display("FAIL split_busy4_cycles: got %0d expected 4", c4); end
        n_tests++; if (base2[0] !== 24'd2304000) begin n_failed++; $display("FAIL split_base2_0: got %0d expected 2304000", base2[0]); end
        n_tests++; if (base2[1] !== 24'd0) begin n_failed++; $display("FAIL split_base2_1: got %0d expected 0", base2[1]); end
        n_tests++; if (max2[0] !== 24'd3072000) begin n_failed++; $display("FAIL split_max2_0: got %0d expected 3072000", max2[0]); end
        n_tests++; if (max2[1] !== 24'd768000) begin n_failed++; $display("FAIL split_max2_1: got %0d expected 768000", max2[1]); end
        n_tests++; if (base4[3] !== 24'd1536000) begin n_failed++; $display("FAIL split_base4_3: got %0d expected 1536000", base4[3]); end
    endtask

    task automatic test_gesture_east();
        int c2, c4;
        pulse_w();                 // pend 3 -> 0
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[1] !== 24'd384000) begin n_failed++; $display("FAIL east_pre_base2_1: got %0d expected 384000", base2[1]); end
        pulse_e();                 // pend 0 -> 3
        repeat (2) tick();
        n_tests++; if (base2[0] !== 24'd0) begin n_failed++; $display("FAIL east_held_base2_0: got %0d expected 0", base2[0]); end
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[0] !== 24'd2304000) begin n_failed++; $display("FAIL east_base2_0: got %0d expected 2304000", base2[0]); end
        n_tests++; if (base2[1] !== 24'd2688000) begin n_failed++; $display("FAIL east_base2_1: got %0d expected 2688000", base2[1]); end
        n_tests++; if (max2[1] !== 24'd3072000) begin n_failed++; $display("FAIL east_max2_1: got %0d expected 3072000", max2[1]); end
        n_tests++; if (base4[1] !== 24'd2496000) begin n_failed++; $display("FAIL east_base4_1: got %0d expected 2496000", base4[1]); end
    endtask

    task automatic test_conflict_and_shrink();
        int c2, c4;
        gest_e = 1'b1; gest_w = 1'b1; tick(); gest_e = 1'b0; gest_w = 1'b0;
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[0] !== 24'd2304000) begin n_failed++; $display("FAIL conflict_base2_0: got %0d expected 2304000", base2[0]); end
        tot = 8'd2;
        repeat (2) tick();
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[0] !== 24'd0) begin n_failed++; $display("FAIL shrink_base2_0: got %0d expected 0", base2[0]); end
        pulse_w();                 // 0 -> 1
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[0] !== 24'd768000) begin n_failed++; $display("FAIL t2_west_base2_0: got %0d expected 768000", base2[0]); end
        pulse_w();                 // 1 -> 0 (wrap)
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[0] !== 24'd0) begin n_failed++; $display("FAIL t2_wrap_base2_0: got %0d expected 0", base2[0]); end
        pulse_e();                 // 0 -> 1 (wrap)
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[1] !== 24'd1152000) begin n_failed++; $display("FAIL t2_east_base2_1: got %0d expected 1152000", base2[1]); end
        tot = 8'd0;                // behaves as one slide; pend 1 -> 0
        repeat (2) tick();
        pulse_w();
        run_frame(1'b1, c2, c4);
        n_tests++; if (base2[1] !== 24'd0) begin n_failed++; $display("FAIL tot0_base2_1: got %0d expected 0", base2[1]); end
        n_tests++; if (max2[1] !== 24'd768000) begin n_failed++; $display("FAIL tot0_max2_1: got %0d expected 768000", max2[1]); end
        n_tests++; if (base4[3] !== 24'd0) begin n_failed++; $display("FAIL tot0_base4_3: got %0d expected 0", base4[3]); end
        tot = 8'd4;
    endtask

    task automatic test_load_new();
        new_frame = 1'b1;
        #1;
        n_tests++; if (mmu2.o_load_new !== 2'b00) begin n_failed++; $display("FAIL load_new_pre: got %b expected 00", mmu2.o_load_new); end
        tick();
        new_frame = 1'b0;
        n_tests++; if (mmu2.o_load_new !== 2'b11) begin n_failed++; $display("FAIL load_new2: got %b expected 11", mmu2.o_load_new); end
        n_tests++; if (mmu4.o_load_new !== 4'hF) begin n_failed++; $display("FAIL load_new4: got %b expected 1111", mmu4.o_load_new); end
        tick();
        n_tests++; if (mmu2.o_load_new !== 2'b00) begin n_failed++; $display("FAIL load_new_post: got %b expected 00", mmu2.o_load_new); end
    endtask

    task automatic test_band_select();
        logic [9:0] ys  [5] = '{10'd0, 10'd119, 10'd120, 10'd479, 10'd700};
        logic [3:0] exp [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b1000};
        next_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cur_y = ys[i];
            #1;
            n_tests++; if (mmu4.o_read_enable !== exp[i]) begin n_failed++; $display("FAIL rden4_y%0d: got %b expected %b", ys[i], mmu4.o_read_enable, exp[i]); end
        end
        cur_y = 10'd239; #1;
        n_tests++; if (mmu2.o_read_enable !== 2'b01) begin n_failed++; $display("FAIL rden2_y239: got %b expected 01", mmu2.o_read_enable); end
        cur_y = 10'd240; #1;
        n_tests++; if (mmu2.o_read_enable !== 2'b10) begin n_failed++; $display("FAIL rden2_y240: got %b expected 10", mmu2.o_read_enable); end
        next_active = 1'b0; #1;
        n_tests++; if (mmu2.o_read_enable !== 2'b00) begin n_failed++; $display("FAIL rden2_idle: got %b expected 00", mmu2.o_read_enable); end
        image_loaded = 1'b0; cur_y = 10'd120; #1;
        n_tests++; if (pix4 !== 32'h001080D0) begin n_failed++; $display("FAIL pix_bg: got %h expected 001080d0", pix4); end
        image_loaded = 1'b1; #1;
        n_tests++; if (pix4 !== 32'h22222222) begin n_failed++; $display("FAIL pix4_y120: got %h expected 22222222", pix4); end
        cur_y = 10'd479; #1;
        n_tests++; if (pix4 !== 32'h44444444) begin n_failed++; $display("FAIL pix4_y479: got %h expected 44444444", pix4); end
        n_tests++; if (pix2 !== 32'hBBBBBBBB) begin n_failed++; $display("FAIL pix2_y479: got %h expected bbbbbbbb", pix2); end
        cur_y = 10'd0; #1;
        n_tests++; if (pix2 !== 32'hAAAAAAAA) begin n_failed++; $display("FAIL pix2_y0: got %h expected aaaaaaaa", pix2); end
        tick();
    endtask

    // Frame end repeated during CALC is ignored; a gesture during CALC is held for the next frame.
    task automatic test_back_to_back();
        int c2, c4, guard;
        mode_split = 1'b0;
        end_frame = 1'b1; tick();
        c2 = 0; guard = 0;
        if (busy2) c2++;
        gest_w = 1'b1; tick();
        end_frame = 1'b0; gest_w = 1'b0;
        while ((busy2 || busy4) && guard < 20) begin
            if (busy2) c2++;
            guard++;
            tick();
        end
        n_tests++; if (c2 != 2) begin n_failed++; $display("FAIL b2b_busy_cycles: got %0d expected 2", c2); end
        n_tests++; if (base2[0] !== 24'd0) begin n_failed++; $display("FAIL b2b_base2_0: got %0d expected 0", base2[0]); end
        run_frame(1'b0, c2, c4);
        n_tests++; if (base2[0] !== 24'd768000) begin n_failed++; $display("FAIL b2b_next_base2_0: got %0d expected 768000", base2[0]); end
    endtask

    task automatic test_reset_mid_calc();
        pulse_w();                 // pend 1 -> 2
        mode_split = 1'b1;
        end_frame = 1'b1; tick(); end_frame = 1'b0;
        tick();                    // band 0 written, now on CALC cycle 1
        n_tests++; if (base2[0] !== 24'd1536000) begin n_failed++; $display("FAIL midcalc_pre_base2_0: got %0d expected 1536000", base2[0]); end
        n_tests++; if (busy2 !== 1'b1) begin n_failed++; $display("FAIL midcalc_pre_busy: got %b expected 1", busy2); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy2 !== 1'b0) begin n_failed++; $display("FAIL midcalc_busy2: got %b expected 0", busy2); end
        n_tests++; if (busy4 !== 1'b0) begin n_failed++; $display("FAIL midcalc_busy4: got %b expected 0", busy4); end
        n_tests++; if (base2[0] !== 24'd0) begin n_failed++; $display("FAIL midcalc_base2_0: got %0d expected 0", base2[0]); end
        n_tests++; if (base2[1] !== 24'd384000) begin n_failed++; $display("FAIL midcalc_base2_1: got %0d expected 384000", base2[1]); end
        n_tests++; if (max2[0] !== 24'd384000) begin n_failed++; $display("FAIL midcalc_max2_0: got %0d expected 384000", max2[0]); end
        n_tests++; if (base4[0] !== 24'd0) begin n_failed++; $display("FAIL midcalc_base4_0: got %0d expected 0", base4[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tot = 8'd4; image_loaded = 1'b0;
        gest_e = 1'b0; gest_w = 1'b0; mode_split = 1'b0;
        new_frame = 1'b0; end_frame = 1'b0; next_active = 1'b0; cur_y = '0;
        mmu2.i_readdata = {32'hBBBBBBBB, 32'hAAAAAAAA};
        mmu4.i_readdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        test_reset();
        test_slide_split();
        test_gesture_east();
        test_conflict_and_shrink();
        test_load_new();
        test_band_select();
        test_back_to_back();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
